// File: rtl/s2p_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel frame driver.
package s2p_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2
  } state_e;

  function automatic int dw_of(input int chain);
    return BYTE_W * chain;
  endfunction

  // Bit-counter width; a one-bit counter is the floor even for tiny frames.
  function automatic int cw_of(input int chain);
    int w;
    w = $clog2(BYTE_W * chain);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/s2p_frame_drv.sv
// Serialises a parallel frame MSB-first into a daisy chain of 8-bit
// shift/latch registers, then strobes the storage latch once.
//
// state | meaning
// IDLE  | sin parked at IDLE_BIT, ready for a frame
// SHIFT | frame bits leaving on sin, MSB first
// LATCH | chain full; st_clk high for one period, next frame may be accepted
module s2p_frame_drv
  import s2p_pkg::*;
#(
  parameter int   CHAIN    = 1,
  parameter logic IDLE_BIT = 1'b0,
  localparam int  DW       = dw_of(CHAIN),
  localparam int  CW       = cw_of(CHAIN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic          oe_en,
  output logic          sin,
  output logic          st_clk,
  output logic          oe_n,
  output logic          busy
);

  localparam logic [1:0] IDLE  = S_IDLE;
  localparam logic [1:0] SHIFT = S_SHIFT;
  localparam logic [1:0] LATCH = S_LATCH;

  logic [1:0]    state;
  logic [1:0]    nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_m1;
  logic [DW-1:0] shadow;
  logic          loaded;
  logic          accept;
  logic          strobe;

  assign accept = din_valid & din_ready;
  assign cnt_m1 = cnt - 1'b1;
  assign strobe = (state == LATCH);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = SHIFT;
      SHIFT:   if (cnt == '0) nxt = LATCH;
      LATCH:   nxt = accept ? SHIFT : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shadow    <= '0;
      sin       <= IDLE_BIT;
      din_ready <= 1'b0;
      busy      <= 1'b0;
      loaded    <= 1'b0;
      oe_n      <= 1'b1;
    end else begin
      state     <= nxt;
      din_ready <= (nxt != SHIFT);
      busy      <= (nxt != IDLE);
      oe_n      <= ~(oe_en & loaded);
      if (state == LATCH) loaded <= 1'b1;

      if (accept) begin
        shadow <= din;
        sin    <= din[DW-1];
        cnt    <= CW'(DW - 1);
      end else if (state == SHIFT) begin
        if (cnt == '0) begin
          sin <= IDLE_BIT;
        end else begin
          sin <= shadow[cnt_m1];
          cnt <= cnt_m1;
        end
      end else begin
        sin <= IDLE_BIT;
      end
    end
  end

  // Falling-edge strobe: the latch samples midway between shift edges.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) st_clk <= 1'b0;
    else        st_clk <= strobe;
  end

endmodule

// File: tb/tb_s2p_frame_drv.sv
// Bench for s2p_frame_drv: CHAIN=1 and CHAIN=2 instances driving
// behavioural models of the downstream shift/latch devices.
module tb_s2p_frame_drv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // CHAIN=1, IDLE_BIT=0
  logic       rst1 = 1'b1;
  logic [7:0] din1 = '0;
  logic       valid1 = 1'b0, oe_en1 = 1'b1;
  logic       ready1, sin1, st1, oen1, busy1;

  // CHAIN=2, IDLE_BIT=1
  logic        rst2 = 1'b1;
  logic [15:0] din2 = '0;
  logic        valid2 = 1'b0, oe_en2 = 1'b1;
  logic        ready2, sin2, st2, oen2, busy2;

  s2p_frame_drv #(.CHAIN(1), .IDLE_BIT(1'b0)) dut1 (
    .clk(clk), .rst_n(rst1), .din(din1), .din_valid(valid1), .din_ready(ready1),
    .oe_en(oe_en1), .sin(sin1), .st_clk(st1), .oe_n(oen1), .busy(busy1)
  );

  s2p_frame_drv #(.CHAIN(2), .IDLE_BIT(1'b1)) dut2 (
    .clk(clk), .rst_n(rst2), .din(din2), .din_valid(valid2), .din_ready(ready2),
    .oe_en(oe_en2), .sin(sin2), .st_clk(st2), .oe_n(oen2), .busy(busy2)
  );

  // Downstream device models: shift on every clk, latch on st_clk rise.
  logic [7:0] sr1 = '0, lat1 = '0;
  int         pulses1 = 0;
  time        rise1 = 0, rise1_prev = 0;
  always @(posedge clk) sr1 <= {sr1[6:0], sin1};
  always @(posedge st1) begin
    lat1       <= sr1;
    pulses1    = pulses1 + 1;
    rise1_prev = rise1;
    rise1      = $time;
  end

  logic [7:0] d2a = '0, d2b = '0, l2a = '0, l2b = '0;
  int         pulses2 = 0;
  always @(posedge clk) begin
    d2a <= {d2a[6:0], sin2};
    d2b <= {d2b[6:0], d2a[7]};
  end
  always @(posedge st2) begin
    l2a     <= d2a;
    l2b     <= d2b;
    pulses2 = pulses2 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts at the accept edge (din1/valid1 already set); returns just after
  // the st_clk rise. 'keep'/'nxt' set the inputs seen by the LATCH edge.
  task automatic frame1(input logic [7:0] d, input bit keep, input logic [7:0] nxt,
                        input bit glitch);
    int p0;
    p0 = pulses1;
    tick();
    valid1 = keep;
    din1   = nxt;
    chk("f1_sin_msb", sin1, d[7]);
    chk("f1_busy", busy1, 1);
    for (int k = 1; k < 8; k++) begin
      if (glitch && k == 3) begin valid1 = 1'b1; din1 = 8'hC3; end
      if (glitch && k == 5) begin valid1 = keep; din1 = nxt; end
      tick();
      chk("f1_sin", sin1, d[7-k]);
      chk("f1_ready_low", ready1, 0);
    end
    tick();
    chk("f1_sin_idle", sin1, 0);
    chk("f1_ready_latch", ready1, 1);
    chk("f1_st_early", st1, 0);
    chk("f1_no_pulse_yet", pulses1, p0);
    @(negedge clk);
    #1;
    chk("f1_st_high", st1, 1);
    chk("f1_one_pulse", pulses1, p0 + 1);
    chk("f1_dout", lat1, d);
  endtask

  task automatic frame2(input logic [15:0] d);
    int p0;
    p0 = pulses2;
    din2   = d;
    valid2 = 1'b1;
    tick();
    valid2 = 1'b0;
    chk("f2_sin_msb", sin2, d[15]);
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("f2_sin", sin2, d[15-k]);
      chk("f2_ready_low", ready2, 0);
    end
    tick();
    chk("f2_sin_idle", sin2, 1);
    @(negedge clk);
    #1;
    chk("f2_st_high", st2, 1);
    chk("f2_one_pulse", pulses2, p0 + 1);
    chk("f2_dev1", l2a, d[7:0]);
    chk("f2_dev2", l2b, d[15:8]);
    tick();
    chk("f2_busy_done", busy2, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] cur, nx, r;
    bit         kp;
    int         p0;

    #1;
    rst1 = 1'b0;
    rst2 = 1'b0;
    #2;
    chk("rst_sin1", sin1, 0);
    chk("rst_sin2", sin2, 1);
    chk("rst_st1", st1, 0);
    chk("rst_oen1", oen1, 1);
    chk("rst_ready1", ready1, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_ready2", ready2, 0);
    @(posedge clk);
    #1;
    rst1 = 1'b1;
    rst2 = 1'b1;
    tick();
    chk("ready1_after_rst", ready1, 1);
    chk("ready2_after_rst", ready2, 1);

    // 1: single frame A5, pulse width and oe_n timing
    din1 = 8'hA5; valid1 = 1'b1;
    frame1(8'hA5, 0, 8'h00, 0);
    tick();
    chk("t1_st_still_high", st1, 1);
    chk("t1_busy_low", busy1, 0);
    chk("t1_oen_edge9", oen1, 1);
    @(negedge clk);
    #1;
    chk("t1_st_low", st1, 0);
    tick();
    chk("t1_oen_edge10", oen1, 0);

    // 2: back-to-back A5 then 3C
    din1 = 8'hA5; valid1 = 1'b1;
    frame1(8'hA5, 1, 8'h3C, 0);
    frame1(8'h3C, 0, 8'h00, 0);
    chk("t2_pulse_spacing", 32'(rise1 - rise1_prev), 90);
    tick();
    chk("t2_busy_low", busy1, 0);

    // 3: CHAIN=2
    frame2(16'h1234);
    frame2(16'($urandom));
    frame2(16'($urandom));

    // 4: reset mid-frame keeps the latch
    din1 = 8'hFF; valid1 = 1'b1;
    frame1(8'hFF, 0, 8'h00, 0);
    tick();
    din1 = 8'h00; valid1 = 1'b1;
    tick();
    valid1 = 1'b0;
    repeat (4) tick();
    rst1 = 1'b0;
    #1;
    chk("t4_rst_st", st1, 0);
    chk("t4_rst_oen", oen1, 1);
    chk("t4_rst_busy", busy1, 0);
    chk("t4_rst_ready", ready1, 0);
    p0 = pulses1;
    repeat (3) tick();
    rst1 = 1'b1;
    tick();
    chk("t4_ready_back", ready1, 1);
    chk("t4_no_pulse", pulses1, p0);
    chk("t4_dout_kept", lat1, 8'hFF);
    chk("t4_oen_hiz", oen1, 1);
    din1 = 8'h00; valid1 = 1'b1;
    frame1(8'h00, 0, 8'h00, 0);
    tick();
    chk("t4_oen_still1", oen1, 1);
    tick();
    chk("t4_oen_on", oen1, 0);

    // 5: oe_en low through a frame
    oe_en1 = 1'b0;
    tick();
    chk("t5_oen_off", oen1, 1);
    r = 8'($urandom);
    din1 = r; valid1 = 1'b1;
    frame1(r, 0, 8'h00, 0);
    repeat (3) tick();
    chk("t5_oen_stays", oen1, 1);
    oe_en1 = 1'b1;
    tick();
    chk("t5_oen_raise", oen1, 0);
    oe_en1 = 1'b0;
    tick();
    chk("t5_oen_drop", oen1, 1);
    oe_en1 = 1'b1;
    tick();

    // 6: din_valid glitch during SHIFT is ignored
    din1 = 8'h5A; valid1 = 1'b1;
    frame1(8'h5A, 0, 8'h00, 1);
    tick();
    chk("t6_busy_edge9", busy1, 0);
    chk("t6_dout", lat1, 8'h5A);

    // 7: reset while st_clk is high drops it immediately
    r = 8'($urandom);
    din1 = r; valid1 = 1'b1;
    frame1(r, 0, 8'h00, 0);
    rst1 = 1'b0;
    #1;
    chk("t7_st_forced_low", st1, 0);
    repeat (2) tick();
    rst1 = 1'b1;
    tick();

    // Random frames, randomly chained back-to-back
    cur = 8'($urandom);
    din1 = cur; valid1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nx = 8'($urandom);
      kp = (i < 5) && ($urandom_range(0, 1) == 1);
      frame1(cur, kp, nx, 0);
      if (!kp) begin
        tick();
        chk("rnd_busy_low", busy1, 0);
        nx = 8'($urandom);
        din1 = nx; valid1 = 1'b1;
      end
      cur = nx;
    end
    valid1 = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/s2p_frame_drv.md
Name: s2p_frame_drv

Overview:
Upstream driver for one or more daisy-chained 8-bit serial-to-parallel output registers. Each register shifts sin on every clk, drives a storage latch from st_clk and uses an active-low output enable. The block accepts a parallel frame over a valid/ready handshake, serialises it MSB-first onto sin, and issues one st_clk pulse so the latch captures the complete frame. It also manages oe_n so outputs stay Hi-Z until the first frame has been latched.

Parameters:
CHAIN, 1, number of cascaded 8-bit registers (sout of device k feeds sin of device k+1); frame width DW = 8*CHAIN
IDLE_BIT, 0, value driven on sin when no frame is shifting

Ports:
clk  in  1  system clock; also clocks the downstream shift registers
rst_n  in  1  asynchronous, active-low reset
din  in  DW  frame to send; din[7:0] lands in the first (directly fed) device
din_valid  in  1  frame available
din_ready  out  1  block can accept a frame this cycle
oe_en  in  1  software output-enable request
sin  out  1  serial data to first device
st_clk  out  1  storage-latch clock to all devices
oe_n  out  1  active-low output enable to all devices
busy  out  1  frame in flight (SHIFT or LATCH)

Behaviour:
- Reset values: sin=IDLE_BIT, st_clk=0, oe_n=1, din_ready=0 while rst_n low, busy=0, state IDLE, loaded=0.
- All outputs are registered.
  - st_clk comes from a negedge-clk flop; everything else from posedge flops.
- States:
  - IDLE: din_ready=1.
  - SHIFT: din_ready=0.
  - LATCH: din_ready=1.
- Accept occurs on a posedge with din_valid & din_ready (edge A).
  - Captures din into the shadow register.
  - Sets sin <= din[DW-1] and bit counter cnt <= DW-1.
  - State -> SHIFT.
- SHIFT, per posedge:
  - sin <= shadow[cnt-1], cnt decrements.
  - The downstream register captures one bit on each of edges A+1 .. A+DW.
  - At edge A+DW-1 the last bit (shadow[0]) is presented. At edge A+DW: state -> LATCH, sin <= IDLE_BIT.
- Latch strobe:
  - An internal strobe flag is high while in LATCH.
  - st_clk samples it on the falling clk edge, so it rises at the falling edge between A+DW and A+DW+1, while the shift chain is stable.
  - It stays high for exactly one clk period.
- LATCH, at edge A+DW+1:
  - loaded <= 1.
  - If din_valid, accept the next frame back-to-back (identical to an accept from IDLE). The latch has already sampled, so the new MSB shift is safe. Else state -> IDLE.
  - Minimum frame period is DW+1 clks.
- oe_n <= ~(oe_en & loaded), posedge-registered.
  - De-asserting oe_en releases outputs to Hi-Z on the next edge regardless of state.
- busy = (state != IDLE).
- Counter width is clog2(DW), minimum 1 bit. cnt never wraps: the SHIFT exit is decoded at cnt==0.
- din_valid while din_ready=0 is ignored; din may change freely until accepted.
- Reset mid-frame: the partial frame is abandoned and no st_clk pulse is issued, so the latch keeps its previous contents. A reset during a high st_clk forces st_clk low immediately. oe_n returns to 1 and loaded to 0.
- In IDLE, sin holds IDLE_BIT. The downstream chain keeps shifting, but its latch is untouched.

Decomposition:
- Package s2p_pkg:
  - state enum {IDLE, SHIFT, LATCH}
  - BYTE_W=8
  - function for DW and the counter width from CHAIN
- Sub-module: none required.
  - The negedge strobe flop stays inline; no separate module is needed.

Test Plan:
1. CHAIN=1, oe_en=1, din=8'hA5 accepted at edge 0.
   - sin over edges 0..7 = 1,0,1,0,0,1,0,1.
   - st_clk rises at the negedge after edge 8 and falls one period later.
   - Downstream dout=8'hA5; oe_n=0 after edge 10.
2. CHAIN=1, back-to-back 8'hA5 then 8'h3C with din_valid held.
   - Second accept at edge 9; exactly two st_clk pulses, 9 clks apart.
   - dout goes A5 then 3C; din_ready low on edges 1..7 of each frame.
3. CHAIN=2, din=16'h1234.
   - 16 bits sent MSB-first; one st_clk pulse.
   - Device 1 latches 8'h34, device 2 latches 8'h12.
4. Frame 8'hFF latched, then 8'h00 sent with rst_n pulsed low at edge 4 of the second frame.
   - No st_clk pulse; dout stays 8'hFF, but oe_n=1 (Hi-Z) after reset.
   - After reset, 8'h00 resent and latched correctly.
5. oe_en=0 throughout one frame.
   - Frame latched, oe_n stays 1.
   - Raise oe_en: oe_n=0 one edge later. Drop oe_en: oe_n=1 one edge later.
6. din_valid pulsed high only during SHIFT of frame 8'h5A, with din=8'hC3.
   - Ignored; only 8'h5A is latched and busy returns low at edge 9.
